// File: rtl/sprite_pkg.sv
// sprite_pkg: shared raster/sprite defaults, FSM encoding and clamp helper
package sprite_pkg;
   localparam int DEF_SCREEN_W   = 640;
   localparam int DEF_SCREEN_H   = 480;
   localparam int DEF_SPRITE_WID = 40;
   localparam int DEF_SPRITE_HGT = 40;
   typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;
   function automatic logic [10:0] clamp(input logic [10:0] v, input logic [10:0] mx);
      return (v > mx) ? mx : v;
   endfunction
endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: one-axis bounded step with reflection at 0 and max
module sprite_axis_step (
   input  logic [10:0] pos,
   input  logic        dir,
   input  logic [3:0]  spd,
   input  logic [10:0] max,
   output logic [9:0]  new_pos,
   output logic        new_dir,
   output logic        bounce
);
   logic [10:0] sum;
   logic        over, under;
   // Saturate at the travel limits and reverse direction when a limit is crossed
   always_comb begin
      sum     = pos + 11'(spd);
      over    = !dir && (sum > max);
      under   = dir && (pos < 11'(spd));
      bounce  = over || under;
      new_dir = bounce ? ~dir : dir;
      new_pos = 10'(over ? max : under ? 11'd0 : dir ? pos - 11'(spd) : sum);
   end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame sprite motion with edge bounce, load and commit
module sprite_motion_ctrl import sprite_pkg::*; #(
   parameter int SCREEN_W   = DEF_SCREEN_W,
   parameter int SCREEN_H   = DEF_SCREEN_H,
   parameter int SPRITE_WID = DEF_SPRITE_WID,
   parameter int SPRITE_HGT = DEF_SPRITE_HGT,
   parameter int START_X    = 300,
   parameter int START_Y    = 220
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [9:0] RASTER_X,
   input  logic [8:0] RASTER_Y,
   input  logic       ENABLE,
   input  logic       SHOW,
   input  logic [3:0] SPEED_X,
   input  logic [3:0] SPEED_Y,
   input  logic       LOAD,
   input  logic [9:0] LOAD_X,
   input  logic [8:0] LOAD_Y,
   output logic [9:0] SPRITE_ORIGIN_OFFSET_X,
   output logic [8:0] SPRITE_ORIGIN_OFFSET_Y,
   output logic       VISIBLE,
   output logic       FRAME_TICK,
   output logic       BOUNCE_X,
   output logic       BOUNCE_Y,
   output logic       BUSY
);
   localparam logic [10:0] MAX_X = 11'(SCREEN_W - SPRITE_WID);
   localparam logic [10:0] MAX_Y = 11'(SCREEN_H - SPRITE_HGT);
   state_t      state, nxt;
   logic        eof_q, eof_raw, eof, sel_y, step_en;
   logic [9:0]  pos_x;
   logic [8:0]  pos_y;
   logic        dir_x, dir_y;
   logic [10:0] s_pos, s_max;
   logic [3:0]  s_spd;
   logic        s_dir, n_dir, n_bnc;
   logic [9:0]  n_pos;
   assign eof_raw = (RASTER_X == 10'(SCREEN_W - 1)) && (RASTER_Y == 9'(SCREEN_H - 1));
   assign eof     = eof_raw && !eof_q;
   assign BUSY    = (state != IDLE);
   // Next state; a load during a step aborts the frame, eof is only honoured in IDLE
   always_comb begin
      nxt = (LOAD && (state == STEP_X || state == STEP_Y)) ? IDLE :
            (state == IDLE)   ? (eof ? STEP_X : IDLE) :
            (state == STEP_X) ? STEP_Y :
            (state == STEP_Y) ? COMMIT : IDLE;
   end
   // Route the active axis into the shared step unit
   always_comb begin
      sel_y   = (state == STEP_Y);
      step_en = ENABLE && !LOAD && (state == STEP_X || state == STEP_Y);
      s_pos   = sel_y ? {2'b0, pos_y} : {1'b0, pos_x};
      s_dir   = sel_y ? dir_y : dir_x;
      s_spd   = sel_y ? SPEED_Y : SPEED_X;
      s_max   = sel_y ? MAX_Y : MAX_X;
   end
   sprite_axis_step u_step (
      .pos     (s_pos),
      .dir     (s_dir),
      .spd     (s_spd),
      .max     (s_max),
      .new_pos (n_pos),
      .new_dir (n_dir),
      .bounce  (n_bnc)
   );
   // State, working position, pulses and committed outputs
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state                  <= IDLE;
         eof_q                  <= 1'b0;
         pos_x                  <= 10'(START_X);
         pos_y                  <= 9'(START_Y);
         dir_x                  <= 1'b0;
         dir_y                  <= 1'b0;
         SPRITE_ORIGIN_OFFSET_X <= 10'(START_X);
         SPRITE_ORIGIN_OFFSET_Y <= 9'(START_Y);
         VISIBLE                <= 1'b0;
         FRAME_TICK             <= 1'b0;
         BOUNCE_X               <= 1'b0;
         BOUNCE_Y               <= 1'b0;
      end else begin
         state      <= nxt;
         eof_q      <= eof_raw;
         FRAME_TICK <= 1'b0;
         BOUNCE_X   <= 1'b0;
         BOUNCE_Y   <= 1'b0;
         if (LOAD) begin
            pos_x <= 10'(clamp({1'b0, LOAD_X}, MAX_X));
            pos_y <= 9'(clamp({2'b0, LOAD_Y}, MAX_Y));
         end else if (step_en && sel_y) begin
            pos_y    <= 9'(n_pos);
            dir_y    <= n_dir;
            BOUNCE_Y <= n_bnc;
         end else if (step_en) begin
            pos_x    <= n_pos;
            dir_x    <= n_dir;
            BOUNCE_X <= n_bnc;
         end
         if (state == COMMIT) begin
            SPRITE_ORIGIN_OFFSET_X <= pos_x;
            SPRITE_ORIGIN_OFFSET_Y <= pos_y;
            VISIBLE                <= SHOW;
            FRAME_TICK             <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed and random frames checked against a frame-level model
module tb_sprite_motion_ctrl;
   localparam int MAXX = 600;
   localparam int MAXY = 440;
   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [9:0] RASTER_X = '0;
   logic [8:0] RASTER_Y = '0;
   logic       ENABLE = 1'b0, SHOW = 1'b0, LOAD = 1'b0;
   logic [3:0] SPEED_X = '0, SPEED_Y = '0;
   logic [9:0] LOAD_X = '0;
   logic [8:0] LOAD_Y = '0;
   logic [9:0] SPRITE_ORIGIN_OFFSET_X;
   logic [8:0] SPRITE_ORIGIN_OFFSET_Y;
   logic       VISIBLE, FRAME_TICK, BOUNCE_X, BOUNCE_Y, BUSY;
   int errors = 0, checks = 0;
   int mx, my, mdx, mdy, ox, oy, ov;

   sprite_motion_ctrl dut (
      .CLK(CLK), .RESET(RESET), .RASTER_X(RASTER_X), .RASTER_Y(RASTER_Y),
      .ENABLE(ENABLE), .SHOW(SHOW), .SPEED_X(SPEED_X), .SPEED_Y(SPEED_Y),
      .LOAD(LOAD), .LOAD_X(LOAD_X), .LOAD_Y(LOAD_Y),
      .SPRITE_ORIGIN_OFFSET_X(SPRITE_ORIGIN_OFFSET_X),
      .SPRITE_ORIGIN_OFFSET_Y(SPRITE_ORIGIN_OFFSET_Y),
      .VISIBLE(VISIBLE), .FRAME_TICK(FRAME_TICK),
      .BOUNCE_X(BOUNCE_X), .BOUNCE_Y(BOUNCE_Y), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   function automatic void step(inout int p, inout int d, input int spd, input int m,
                                input bit en, output bit b);
      b = 1'b0;
      if (!en || spd == 0) return;
      if (d == 0) begin
         if (p + spd > m) begin p = m; d = 1; b = 1'b1; end
         else p = p + spd;
      end else begin
         if (p < spd) begin p = 0; d = 0; b = 1'b1; end
         else p = p - spd;
      end
   endfunction

   task automatic model_reset();
      mx = 300; my = 220; mdx = 0; mdy = 0; ox = 300; oy = 220; ov = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_x"}, 32'(SPRITE_ORIGIN_OFFSET_X), 32'(ox));
      chk({tag, "_y"}, 32'(SPRITE_ORIGIN_OFFSET_Y), 32'(oy));
      chk({tag, "_vis"}, 32'(VISIBLE), 32'(ov));
      chk({tag, "_busy"}, 32'(BUSY), 32'd0);
   endtask

   task automatic load_pos(input int lx, input int ly);
      LOAD = 1'b1; LOAD_X = 10'(lx); LOAD_Y = 9'(ly);
      @(posedge CLK); #1;
      LOAD = 1'b0;
      mx = clampv(lx, MAXX); my = clampv(ly, MAXY);
   endtask

   // load_at: 0 none, 1 during STEP_X, 2 during STEP_Y, 3 during COMMIT
   task automatic frame(input string tag, input int hold, input int load_at,
                        input int lx, input int ly);
      int ticks = 0, bxc = 0, byc = 0, tick_i = -1, bx_i = -1, by_i = -1;
      int ex_t = 0;
      bit ebx = 1'b0, eby = 1'b0;
      if (load_at == 1) begin
         mx = clampv(lx, MAXX); my = clampv(ly, MAXY);
      end else begin
         step(mx, mdx, int'(SPEED_X), MAXX, ENABLE, ebx);
         if (load_at == 2) begin
            mx = clampv(lx, MAXX); my = clampv(ly, MAXY);
         end else begin
            step(my, mdy, int'(SPEED_Y), MAXY, ENABLE, eby);
            ox = mx; oy = my; ov = int'(SHOW); ex_t = 1;
            if (load_at == 3) begin mx = clampv(lx, MAXX); my = clampv(ly, MAXY); end
         end
      end
      for (int i = 0; i < 10; i++) begin
         RASTER_X = (i < hold) ? 10'd639 : 10'd0;
         RASTER_Y = (i < hold) ? 9'd479 : 9'd0;
         LOAD = (load_at > 0 && i == load_at);
         LOAD_X = 10'(lx); LOAD_Y = 9'(ly);
         @(posedge CLK); #1;
         if (FRAME_TICK) begin ticks++; if (tick_i < 0) tick_i = i; end
         if (BOUNCE_X) begin bxc++; if (bx_i < 0) bx_i = i; end
         if (BOUNCE_Y) begin byc++; if (by_i < 0) by_i = i; end
      end
      LOAD = 1'b0;
      chk({tag, "_ticks"}, 32'(ticks), 32'(ex_t));
      chk({tag, "_bx"}, 32'(bxc), 32'(ebx));
      chk({tag, "_by"}, 32'(byc), 32'(eby));
      if (ex_t != 0) chk({tag, "_lat"}, 32'(tick_i), 32'd3);
      if (ebx) chk({tag, "_bx_at"}, 32'(bx_i), 32'd1);
      if (eby) chk({tag, "_by_at"}, 32'(by_i), 32'd2);
      check_outputs(tag);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      check_outputs("reset");
      chk("reset_tick", 32'(FRAME_TICK), 32'd0);
      chk("reset_bx", 32'(BOUNCE_X), 32'd0);
      chk("reset_by", 32'(BOUNCE_Y), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;

      SHOW = 1'b1; ENABLE = 1'b1; SPEED_X = 0; SPEED_Y = 0;
      frame("first", 1, 0, 0, 0);

      load_pos(598, 220);
      SPEED_X = 5;
      frame("xbounce", 1, 0, 0, 0);
      chk("xbounce_dir_next", 32'(SPRITE_ORIGIN_OFFSET_X), 32'd600);

      SPEED_X = 0; SPEED_Y = 7;
      load_pos(600, 438);
      frame("ybounce_bot", 1, 0, 0, 0);
      load_pos(600, 3);
      frame("ybounce_top", 1, 0, 0, 0);
      chk("ybounce_top_y", 32'(SPRITE_ORIGIN_OFFSET_Y), 32'd0);

      SPEED_X = 3; SPEED_Y = 2;
      frame("hold4", 4, 0, 0, 0);

      frame("load_stepy", 1, 2, 700, 100);
      frame("after_load", 1, 0, 0, 0);

      ENABLE = 1'b0;
      for (int f = 0; f < 3; f++) begin
         SHOW = f[0];
         frame("disabled", 2, 0, 0, 0);
      end
      ENABLE = 1'b1;

      for (int f = 0; f < 25; f++) begin
         int la;
         ENABLE  = ($urandom_range(0, 4) != 0);
         SHOW    = 1'($urandom);
         SPEED_X = 4'($urandom);
         SPEED_Y = 4'($urandom);
         if ($urandom_range(0, 3) == 0) load_pos($urandom_range(0, 1023), $urandom_range(0, 511));
         la = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         frame("rand", $urandom_range(1, 5), la, $urandom_range(0, 1023), $urandom_range(0, 511));
      end

      RASTER_X = 10'd639; RASTER_Y = 9'd479;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      #1;
      model_reset();
      check_outputs("midreset");
      @(posedge CLK); #1;
      RASTER_X = 0; RASTER_Y = 0;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;
      ENABLE = 1'b1; SHOW = 1'b1; SPEED_X = 4; SPEED_Y = 9;
      frame("fresh", 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- SCREEN_W, 640, visible raster width in pixels.
- SCREEN_H, 480, visible raster height in lines.
- SPRITE_WID, 40, sprite width.
- SPRITE_HGT, 40, sprite height.
- START_X, 300, reset X origin.
- START_Y, 220, reset Y origin.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- CLK, in, 1, sole clock.
- RESET, in, 1, asynchronous, active-low reset.
- RASTER_X, in, 10, current raster column.
- RASTER_Y, in, 9, current raster line.
- ENABLE, in, 1, motion enable.
- SHOW, in, 1, requested sprite visibility.
- SPEED_X, in, 4, X pixels per frame.
- SPEED_Y, in, 4, Y pixels per frame.
- LOAD, in, 1, one-cycle pulse to load a position.
- LOAD_X, in, 10, position to load, X.
- LOAD_Y, in, 9, position to load, Y.
- SPRITE_ORIGIN_OFFSET_X, out, 10, registered sprite origin X.
- SPRITE_ORIGIN_OFFSET_Y, out, 9, registered sprite origin Y.
- VISIBLE, out, 1, registered visibility.
- FRAME_TICK, out, 1, one-cycle pulse on each commit.
- BOUNCE_X, out, 1, one-cycle pulse when X reverses.
- BOUNCE_Y, out, 1, one-cycle pulse when Y reverses.
- BUSY, out, 1, high in any state other than IDLE.

Function
REQ-003 SHALL register (RASTER_X==SCREEN_W-1 && RASTER_Y==SCREEN_H-1) and generate an end-of-frame (eof) pulse only on its rising edge, so a raster position held for several CLK cycles yields exactly one eof.
REQ-004 SHALL implement FSM states IDLE, STEP_X, STEP_Y and COMMIT; each non-IDLE state lasts exactly one cycle.
REQ-005 SHALL transition IDLE to STEP_X on eof; STEP_X to STEP_Y; STEP_Y to COMMIT; COMMIT to IDLE.
REQ-006 SHALL hold working registers pos_x, pos_y, dir_x and dir_y (dir 0 = increasing, 1 = decreasing).
REQ-007 SHALL compute steps through a single shared axis-step unit: in STEP_X on (pos_x, dir_x, SPEED_X, SCREEN_W-SPRITE_WID), and in STEP_Y on (pos_y, dir_y, SPEED_Y, SCREEN_H-SPRITE_HGT).
REQ-008 SHALL perform the axis-step arithmetic at 11 bits, unsigned, with no wrap-around:
- dir=0 and pos+spd > max: result is max, dir flips, bounce asserts.
- dir=1 and pos < spd: result is 0, dir flips, bounce asserts.
- Otherwise: result is pos±spd.
REQ-009 SHALL, when ENABLE=0 or spd=0 during a step state, leave pos and dir unchanged and assert no bounce.
REQ-010 SHALL, in COMMIT, copy pos_x and pos_y to the SPRITE_ORIGIN_OFFSET outputs and SHOW to VISIBLE, and pulse FRAME_TICK; the outputs SHALL change at no other time.
REQ-011 SHALL pulse BOUNCE_X in the cycle after STEP_X and BOUNCE_Y in the cycle after STEP_Y, each for one cycle.
REQ-012 SHALL give a latency of 4 cycles from the eof rising edge to updated outputs.
REQ-013 SHALL, on LOAD, clamp LOAD_X to SCREEN_W-SPRITE_WID and LOAD_Y to SCREEN_H-SPRITE_HGT, write the results to pos_x and pos_y, and leave dir unchanged.
REQ-014 SHALL give LOAD priority in STEP_X or STEP_Y: the FSM aborts to IDLE with no commit and no bounce, and the loaded position appears at the next frame's COMMIT.
REQ-015 SHALL, on LOAD during COMMIT, complete the commit with the pre-load position and retain the loaded value for the next frame.
REQ-016 SHALL ignore an eof arriving while BUSY.

Reset
REQ-017 SHALL, while RESET=0 (asynchronous), set:
- state to IDLE
- pos_x and SPRITE_ORIGIN_OFFSET_X to START_X
- pos_y and SPRITE_ORIGIN_OFFSET_Y to START_Y
- dir_x and dir_y to 0
- VISIBLE, FRAME_TICK, BOUNCE_X, BOUNCE_Y, BUSY and the eof-detect register to 0.
REQ-018 SHALL, on reset assertion mid-update, drop the update; the first eof after release starts a fresh sequence.

Structure
REQ-019 SHALL place SCREEN_W, SCREEN_H, SPRITE_WID and SPRITE_HGT defaults and the FSM state encoding in shared package sprite_pkg.
REQ-020 SHALL implement the shared step arithmetic as combinational sub-module sprite_axis_step (inputs pos, dir, spd, max; outputs new_pos, new_dir, bounce), instantiated once.

Verification
REQ-021 SHALL cover:
- Reset release, SHOW=1, one eof → outputs (300,220), VISIBLE=1 after 4 cycles, FRAME_TICK once.
- pos_x=598, dir_x=0, SPEED_X=5 → X=600, dir_x=1, BOUNCE_X once, Y unaffected.
- pos_y=3, dir_y=1, SPEED_Y=7 → Y=0, dir_y=0, BOUNCE_Y once.
- Raster held at (639,479) for 4 CLK → exactly one FRAME_TICK.
- LOAD (700,100) during STEP_Y → no FRAME_TICK this frame; next frame outputs (600,100) ± step.
- ENABLE=0 across 3 frames → position constant, FRAME_TICK each frame, VISIBLE tracks SHOW.
